// File: rtl/mel_frame_buf.sv
// mel_frame_buf: circular mel frame store with oldest-first snapshot readout.
// Build option: define MEL_FBUF_OVERRUN_EN to add sticky overrun detection.
module mel_frame_buf #(
   parameter int WIDTH     = 16,
   parameter int MEL_BANDS = 40,
   parameter int N_FRAMES  = 101
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mel_avail,
   input  logic [WIDTH-1:0] mel_data,
   output logic             frame_tick,
   output logic             spec_ready,
   input  logic             rd_start,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             overrun
);
   localparam int SLOTS  = N_FRAMES + 1;
   localparam int DEPTH  = SLOTS * MEL_BANDS;
   localparam int SLOT_W = $clog2(SLOTS);
   localparam int BAND_W = $clog2(MEL_BANDS);
   localparam int ADDR_W = $clog2(DEPTH);

   typedef enum logic {IDLE, READ} state_t;
   state_t state, state_nxt;

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [BAND_W-1:0] wr_band, rd_band;
   logic [SLOT_W-1:0] wr_slot, frames_valid, rd_frame, base_slot;
   logic [ADDR_W-1:0] wr_addr, rd_addr;
   logic [WIDTH-1:0]  s1_data;
   logic              s1_valid, s1_last, fetch_on;
   logic              wr_last, accept, xfer, adv, rd_en, band_end, fetch_last;

   // shared handshake/addressing terms and next-state; oldest slot sits just past the one being written
   always_comb begin
      wr_last    = mel_avail && wr_band == BAND_W'(MEL_BANDS - 1);
      wr_addr    = ADDR_W'(wr_slot) * ADDR_W'(MEL_BANDS) + ADDR_W'(wr_band);
      base_slot  = wr_slot == SLOT_W'(N_FRAMES) ? '0 : wr_slot + 1'b1;
      accept     = state == IDLE && rd_start && spec_ready;
      xfer       = out_valid && out_ready;
      adv        = !out_valid || out_ready;
      rd_en      = fetch_on && (!s1_valid || adv);
      band_end   = rd_band == BAND_W'(MEL_BANDS - 1);
      fetch_last = band_end && rd_frame == SLOT_W'(N_FRAMES - 1);
      state_nxt  = accept ? READ : (state == READ && xfer && out_last) ? IDLE : state;
   end

   // write side: band/slot counters, frame pulse and saturating fill count
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_band      <= '0;
         wr_slot      <= '0;
         frames_valid <= '0;
         frame_tick   <= 1'b0;
      end else begin
         frame_tick <= wr_last;
         if (mel_avail) wr_band <= wr_last ? '0 : wr_band + 1'b1;
         if (wr_last) begin
            wr_slot <= wr_slot == SLOT_W'(N_FRAMES) ? '0 : wr_slot + 1'b1;
            if (frames_valid != SLOT_W'(N_FRAMES)) frames_valid <= frames_valid + 1'b1;
         end
      end

   // frame store RAM; its read register is the first pipeline stage
   always_ff @(posedge clk) begin
      if (mel_avail) mem[wr_addr] <= mel_data;
      if (rd_en) s1_data <= mem[rd_addr];
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;

   // snapshot available only when idle with a full history
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) spec_ready <= 1'b0;
      else spec_ready <= state == IDLE && !accept && frames_valid == SLOT_W'(N_FRAMES);

   // fetch counters walk the snapshot oldest-first, one RAM read per free pipeline slot
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         fetch_on <= 1'b0;
         rd_frame <= '0;
         rd_band  <= '0;
         rd_addr  <= '0;
      end else if (accept) begin
         fetch_on <= 1'b1;
         rd_frame <= '0;
         rd_band  <= '0;
         rd_addr  <= ADDR_W'(base_slot) * ADDR_W'(MEL_BANDS);
      end else if (rd_en) begin
         rd_band <= band_end ? '0 : rd_band + 1'b1;
         rd_addr <= rd_addr == ADDR_W'(DEPTH - 1) ? '0 : rd_addr + 1'b1;
         if (band_end && !fetch_last) rd_frame <= rd_frame + 1'b1;
         if (fetch_last) fetch_on <= 1'b0;
      end

   // two-stage skid: RAM register feeds the output register, both hold while stalled
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_last   <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else begin
         if (adv) begin
            out_valid <= s1_valid;
            out_last  <= s1_valid && s1_last;
            if (s1_valid) out_data <= s1_data;
         end
         if (rd_en) begin
            s1_valid <= 1'b1;
            s1_last  <= fetch_last;
         end else if (adv) s1_valid <= 1'b0;
      end

`ifdef MEL_FBUF_OVERRUN_EN
   logic [SLOT_W-1:0] wr_done;

   // flag when the writer enters a snapshot frame the reader has not fetched yet
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_done <= '0;
         overrun <= 1'b0;
      end else if (accept) begin
         wr_done <= '0;
         overrun <= 1'b0;
      end else if (state == READ && wr_last) begin
         if (wr_done != SLOT_W'(N_FRAMES)) wr_done <= wr_done + 1'b1;
         if (rd_frame <= wr_done) overrun <= 1'b1;
      end
`else
   assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_mel_frame_buf.sv
// tb_mel_frame_buf: randomized self-checking bench for mel_frame_buf (4 frames x 3 bands).
module tb_mel_frame_buf;
   localparam int NF = 4;
   localparam int NB = 3;
   localparam int NW = NF * NB;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mel_avail = 1'b0;
   logic [15:0] mel_data = '0;
   logic        rd_start = 1'b0;
   logic        out_ready = 1'b1;
   logic        frame_tick, spec_ready, out_valid, out_last, overrun;
   logic [15:0] out_data;

   int checks = 0;
   int errors = 0;
   int fcnt = 0;
   int tick_cnt = 0;
   logic [15:0] hist[$];
   logic [15:0] got[$];
   int lat, last_cnt, last_idx, unstable;
   bit tmo;
   logic sr_acc;

   mel_frame_buf #(.WIDTH(16), .MEL_BANDS(NB), .N_FRAMES(NF)) dut (
      .clk(clk), .rst_n(rst_n), .mel_avail(mel_avail), .mel_data(mel_data),
      .frame_tick(frame_tick), .spec_ready(spec_ready), .rd_start(rd_start),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .overrun(overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (frame_tick) tick_cnt <= tick_cnt + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // one frame of pattern data 0x0100*f+b; the model keeps the last NF complete frames
   task automatic send_frame(input bit gaps);
      for (int b = 0; b < NB; b++) begin
         if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         mel_avail = 1'b1;
         mel_data = 16'((fcnt << 8) + b);
         @(posedge clk); #1;
         mel_avail = 1'b0;
         hist.push_back(16'((fcnt << 8) + b));
      end
      while (hist.size() > NW) void'(hist.pop_front());
      fcnt++;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // requests a snapshot and records every transferred word plus timing/stability observations
   task automatic run_readout(input bit rnd, input bit poke);
      int cyc;
      bit held, done;
      logic [15:0] hd;
      logic hl;
      got.delete();
      lat = -1; last_cnt = 0; last_idx = -1; unstable = 0; tmo = 0;
      held = 0; done = 0; cyc = 0; hd = '0; hl = 1'b0;
      rd_start = 1'b1;
      @(posedge clk); #1;
      rd_start = 1'b0;
      sr_acc = spec_ready;
      while (!done) begin
         if (out_valid && lat < 0) lat = cyc;
         if (held && (!out_valid || out_data !== hd || out_last !== hl)) unstable++;
         if (poke) rd_start = got.size() == 5;
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         held = out_valid && !out_ready;
         hd = out_data;
         hl = out_last;
         if (out_valid && out_ready) begin
            got.push_back(out_data);
            if (out_last) begin
               last_cnt++;
               last_idx = got.size() - 1;
               done = 1;
            end
         end
         @(posedge clk); #1;
         cyc++;
         if (cyc > 400) begin tmo = 1; done = 1; end
      end
      rd_start = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic test_reset;
      idle(3);
      checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_frame_tick got %b want 0", frame_tick); end
      checks++; if (spec_ready !== 1'b0) begin errors++; $display("FAIL reset_spec_ready got %b want 0", spec_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got %h want 0000", out_data); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
      rst_n = 1'b1;
      idle(1);
   endtask

   task automatic test_fill;
      int t0;
      t0 = tick_cnt;
      for (int f = 0; f < NF; f++) begin
         send_frame(1);
         checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL fill_tick_f%0d got %b want 1", f, frame_tick); end
         if (f < NF - 1) begin
            checks++; if (spec_ready !== 1'b0) begin errors++; $display("FAIL fill_early_ready_f%0d got %b want 0", f, spec_ready); end
         end
      end
      checks++; if (spec_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_on_tick got %b want 0", spec_ready); end
      idle(1);
      checks++; if (spec_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_after_tick got %b want 1", spec_ready); end
      checks++; if (tick_cnt - t0 !== NF) begin errors++; $display("FAIL fill_tick_count got %0d want %0d", tick_cnt - t0, NF); end
   endtask

   task automatic test_snapshot;
      logic [15:0] exp[$];
      send_frame(1);
      send_frame(1);
      idle(2);
      exp = hist;
      run_readout(0, 0);
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL snap_timeout got %b want 0", tmo); end
      checks++; if (sr_acc !== 1'b0) begin errors++; $display("FAIL snap_ready_after_accept got %b want 0", sr_acc); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL snap_latency got %0d want 2", lat); end
      checks++; if (got.size() !== NW) begin errors++; $display("FAIL snap_count got %0d want %0d", got.size(), NW); end
      for (int i = 0; i < NW && i < got.size(); i++) begin
         checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL snap_word%0d got %h want %h", i, got[i], exp[i]); end
      end
      checks++; if (last_cnt !== 1 || last_idx !== NW - 1) begin errors++; $display("FAIL snap_last got cnt %0d idx %0d want cnt 1 idx %0d", last_cnt, last_idx, NW - 1); end
      checks++; if (spec_ready !== 1'b0) begin errors++; $display("FAIL snap_ready_on_exit got %b want 0", spec_ready); end
      idle(1);
      checks++; if (spec_ready !== 1'b1) begin errors++; $display("FAIL snap_ready_after_exit got %b want 1", spec_ready); end
   endtask

   task automatic test_backpressure;
      logic [15:0] exp[$];
      for (int r = 0; r < 3; r++) begin
         repeat ($urandom_range(1, 3)) send_frame(1);
         idle(2);
         exp = hist;
         run_readout(1, 0);
         checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL bp%0d_timeout got %b want 0", r, tmo); end
         checks++; if (unstable !== 0) begin errors++; $display("FAIL bp%0d_stall_stable got %0d changes want 0", r, unstable); end
         checks++; if (got.size() !== NW) begin errors++; $display("FAIL bp%0d_count got %0d want %0d", r, got.size(), NW); end
         for (int i = 0; i < NW && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL bp%0d_word%0d got %h want %h", r, i, got[i], exp[i]); end
         end
         checks++; if (last_cnt !== 1 || last_idx !== NW - 1) begin errors++; $display("FAIL bp%0d_last got cnt %0d idx %0d want cnt 1 idx %0d", r, last_cnt, last_idx, NW - 1); end
      end
   endtask

   task automatic test_rd_during_read;
      logic [15:0] exp[$];
      send_frame(1);
      idle(2);
      exp = hist;
      run_readout(1, 1);
      checks++; if (got.size() !== NW) begin errors++; $display("FAIL rdread_count got %0d want %0d", got.size(), NW); end
      for (int i = 0; i < NW && i < got.size(); i++) begin
         checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL rdread_word%0d got %h want %h", i, got[i], exp[i]); end
      end
      idle(4);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rdread_no_restart got %b want 0", out_valid); end
   endtask

   task automatic test_overrun;
      logic [15:0] exp[$];
      logic exp_ov;
      int n, cyc;
      bit fin;
`ifdef MEL_FBUF_OVERRUN_EN
      exp_ov = 1'b1;
`else
      exp_ov = 1'b0;
`endif
      send_frame(1);
      idle(2);
      out_ready = 1'b0;
      rd_start = 1'b1;
      @(posedge clk); #1;
      rd_start = 1'b0;
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_before got %b want 0", overrun); end
      idle(4);
      send_frame(0);
      checks++; if (overrun !== exp_ov) begin errors++; $display("FAIL ovr_set got %b want %b", overrun, exp_ov); end
      out_ready = 1'b1;
      n = 0; cyc = 0; fin = 0;
      while (!fin && cyc < 200) begin
         if (out_valid) begin n++; fin = out_last; end
         @(posedge clk); #1;
         cyc++;
      end
      checks++; if (n !== NW) begin errors++; $display("FAIL ovr_drain_count got %0d want %0d", n, NW); end
      idle(2);
      checks++; if (overrun !== exp_ov) begin errors++; $display("FAIL ovr_sticky got %b want %b", overrun, exp_ov); end
      exp = hist;
      run_readout(0, 0);
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_cleared got %b want 0", overrun); end
      checks++; if (got.size() !== NW) begin errors++; $display("FAIL ovr_next_count got %0d want %0d", got.size(), NW); end
      for (int i = 0; i < NW && i < got.size(); i++) begin
         checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL ovr_next_word%0d got %h want %h", i, got[i], exp[i]); end
      end
      idle(1);
   endtask

   task automatic test_reset_mid;
      int n, cyc;
      idle(1);
      rd_start = 1'b1;
      @(posedge clk); #1;
      rd_start = 1'b0;
      n = 0; cyc = 0;
      while (n < 5 && cyc < 50) begin
         if (out_valid) n++;
         @(posedge clk); #1;
         cyc++;
      end
      checks++; if (n !== 5) begin errors++; $display("FAIL rstmid_words got %0d want 5", n); end
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
      checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL rstmid_out_data got %h want 0000", out_data); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rstmid_out_last got %b want 0", out_last); end
      checks++; if (spec_ready !== 1'b0) begin errors++; $display("FAIL rstmid_spec_ready got %b want 0", spec_ready); end
      checks++; if (frame_tick !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rstmid_tick_ovr got %b%b want 00", frame_tick, overrun); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      hist.delete();
      fcnt = 0;
      for (int f = 0; f < NF - 1; f++) send_frame(1);
      idle(2);
      checks++; if (spec_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready_3frames got %b want 0", spec_ready); end
      send_frame(1);
      idle(1);
      checks++; if (spec_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready_4frames got %b want 1", spec_ready); end
   endtask

   task automatic test_ignored_early;
      bit seen;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      hist.delete();
      fcnt = 0;
      for (int f = 0; f < NF - 1; f++) send_frame(1);
      rd_start = 1'b1;
      @(posedge clk); #1;
      rd_start = 1'b0;
      seen = 0;
      repeat (8) begin
         if (out_valid) seen = 1;
         @(posedge clk); #1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL early_no_valid got %b want 0", seen); end
      checks++; if (spec_ready !== 1'b0) begin errors++; $display("FAIL early_spec_ready got %b want 0", spec_ready); end
   endtask

   initial begin
      test_reset;
      test_fill;
      test_snapshot;
      test_backpressure;
      test_rd_during_read;
      test_overrun;
      test_reset_mid;
      test_ignored_early;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mel_frame_buf.md
# mel_frame_buf

- Consumer end of the mel spectrogram pipeline.
- Captures the per-band `mel_avail`/`mel_data` stream from the mel front end into a circular frame store.
- Holds the last N_FRAMES complete frames.
- On request, streams one oldest-first spectrogram snapshot to a downstream classifier over a valid/ready handshake.

## Interface
- `WIDTH`, 16: mel sample width.
- `MEL_BANDS`, 40: words per frame.
- `N_FRAMES`, 101: frames per snapshot; the store holds N_FRAMES+1 slots.
- Derived: `SLOT_W`=$clog2(N_FRAMES+1), `BAND_W`=$clog2(MEL_BANDS), `ADDR_W`=$clog2((N_FRAMES+1)*MEL_BANDS).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mel_avail` in 1: one mel word valid this cycle. No backpressure.
- `mel_data` in WIDTH: mel word, band order 0..MEL_BANDS-1.
- `frame_tick` out 1: one-cycle pulse when band MEL_BANDS-1 is written.
- `spec_ready` out 1: N_FRAMES complete frames are stored and no readout is in progress.
- `rd_start` in 1: request a snapshot readout.
- `out_valid` out 1: output word valid.
- `out_ready` in 1: consumer accepts the word.
- `out_data` out WIDTH: spectrogram word.
- `out_last` out 1: high with the final word, frame N_FRAMES-1, band MEL_BANDS-1.
- `overrun` out 1: sticky; the writer overwrote unread snapshot data.

## Operation
- Storage: single-port-write / single-port-read synchronous RAM of (N_FRAMES+1)*MEL_BANDS words.
- Write address = `wr_slot`*MEL_BANDS+`wr_band`.
- Write side (always active):
  - On `mel_avail`, write `mel_data`, then increment `wr_band`.
  - At band MEL_BANDS-1: `wr_band`→0, `wr_slot` increments, wrapping N_FRAMES→0, `frame_tick` pulses, `frames_valid` increments (saturates at N_FRAMES).
- FSM states IDLE, READ.
- IDLE→READ on `rd_start && spec_ready`. `rd_start` is ignored in any other case.
- On accept:
  - `base_slot` = (`wr_slot`+1) mod (N_FRAMES+1). This is the oldest complete slot; the slot currently being written is excluded.
  - `rd_frame`=0, `rd_band`=0, `wr_done`=0, `overrun` cleared.
- READ:
  - Words are emitted in order (`base_slot`+`rd_frame`) mod (N_FRAMES+1), band 0..MEL_BANDS-1, for `rd_frame` 0..N_FRAMES-1.
  - A word transfers on `out_valid && out_ready`.
  - `out_valid` does not drop until its word has transferred.
  - `out_data` and `out_last` are held stable while stalled.
- READ→IDLE on transfer of the `out_last` word.
- Overrun detection:
  - During READ, each frame completion increments `wr_done`. The writer then enters snapshot frame index `wr_done`-1.
  - If `rd_frame` ≤ `wr_done`-1 at that moment, set `overrun`.
  - The readout still completes with N_FRAMES*MEL_BANDS words; data content is then undefined.
- Read and write of the same address in one cycle occur only under overrun. The returned data is then don't-care.
- Arithmetic: all counters are unsigned and wrap by compare-and-clear, never by power-of-two truncation. Data passes through unmodified.

## Timing
- Reset values:
  - `frame_tick`=0, `spec_ready`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `overrun`=0.
  - `wr_slot`, `wr_band`, `frames_valid` = 0; FSM in IDLE.
  - RAM is not cleared.
- `frame_tick` is asserted the cycle after the final-band `mel_avail`.
- `spec_ready` is registered.
  - It rises the cycle after `frames_valid` reaches N_FRAMES while IDLE.
  - It falls the cycle after `rd_start` is accepted.
  - It rises again the cycle after the READ→IDLE exit.
- Readout latency: first `out_valid` 2 cycles after the `rd_start` accept edge.
- With `out_ready` held high, one word transfers per cycle with no bubbles. The read path needs a prefetch/skid stage.
- A snapshot takes N_FRAMES*MEL_BANDS transfer cycles minimum.
- `rst_n` asserted mid-readout: outputs return to reset values immediately, and `spec_ready` stays low until N_FRAMES new frames are captured.

## Configuration
- `MEL_FBUF_OVERRUN_EN`
  - Defined: `wr_done` tracking and sticky `overrun` as described above.
  - Undefined: the detection logic is removed, `overrun` is tied 0, and readout behaviour is otherwise identical.

## Test plan
Overrides for all tests: N_FRAMES=4, MEL_BANDS=3, WIDTH=16. Frame f band b carries value 16'h0100*f+b.
- Capture fill: write 4 frames → 4 `frame_tick` pulses; `spec_ready` rises the cycle after the 4th tick.
- Snapshot after 6 frames (f=0..5), `out_ready`=1:
  - 12 words in the order 0x0200, 0x0201, 0x0202, 0x0300, …, 0x0502.
  - `out_last` only on 0x0502; first `out_valid` 2 cycles after accept.
- Backpressure: toggle `out_ready` pseudo-randomly → same 12-word sequence; `out_data` stable while stalled; no duplicates or drops.
- Overrun: build `MEL_FBUF_OVERRUN_EN`; start readout, hold `out_ready`=0, complete 1 more frame → `overrun`=1. The next `rd_start` clears it.
- Ignored requests:
  - `rd_start` with only 3 frames stored → no `out_valid`.
  - `rd_start` during READ → sequence unchanged.
- Reset mid-readout after 5 words → all outputs 0 within the reset; `spec_ready` low until 4 new frames are captured.
